// File: rtl/clz_norm_pipe_pkg.sv
// Shared constants and types for the leading-zero/one counter and normaliser.
package clz_pkg;

    localparam logic CLZ_MODE_ZEROS = 1'b0;
    localparam logic CLZ_MODE_ONES  = 1'b1;

    localparam int unsigned CLZ_MAX_WIDTH = 128;
    localparam int unsigned CLZ_MAX_CW    = 8;

    function automatic int unsigned CLOG2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    // S1->S2 payload at the widest supported configuration.
    typedef struct packed {
        logic [CLZ_MAX_WIDTH-1:0] data;
        logic [CLZ_MAX_CW-1:0]    count;
        logic                     all;
    } clz_payload_t;

endpackage

// File: rtl/clz_norm_pipe_tree.sv
// Combinational leading-zero detector: 2-bit encoders feeding a merge tree.
module clz_tree
    import clz_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]        data,
    output logic [CLOG2(WIDTH)-1:0] pos,
    output logic                    valid
);

    localparam int unsigned LW    = CLOG2(WIDTH);
    localparam int unsigned NODES = WIDTH / 2;

    always_comb begin
        logic [LW-1:0] node_pos [NODES];
        logic          node_vld [NODES];

        // Node 0 covers the most significant pair.
        for (int unsigned i = 0; i < NODES; i++) begin
            node_vld[i]    = data[WIDTH-1-2*i] | data[WIDTH-2-2*i];
            node_pos[i]    = '0;
            node_pos[i][0] = ~data[WIDTH-1-2*i];
        end

        // Merges are done in place: node j reads 2j and 2j+1, which are never below j.
        for (int unsigned lvl = 1; lvl < LW; lvl++) begin
            for (int unsigned j = 0; j < (NODES >> lvl); j++) begin
                if (node_vld[2*j]) begin
                    node_pos[j] = node_pos[2*j];
                end else begin
                    node_pos[j]      = node_pos[2*j+1];
                    node_pos[j][lvl] = 1'b1;
                end
                node_vld[j] = node_vld[2*j] | node_vld[2*j+1];
            end
        end

        pos   = node_pos[0];
        valid = node_vld[0];
    end

endmodule

// File: rtl/clz_norm_pipe.sv
// Two-stage leading-zero/one counter and normaliser with valid/ready handshakes.
// Define CLZ_NORM_SHIFTER_EN to build the normalising barrel shifter; otherwise out_norm is 0.
module clz_norm_pipe
    import clz_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CW    = CLOG2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_all,
    output logic [WIDTH-1:0] out_norm
);

    typedef struct packed {
`ifdef CLZ_NORM_SHIFTER_EN
        logic [WIDTH-1:0] data;
`endif
        logic [CW-1:0]    count;
        logic             all;
    } s1_payload_t;

    logic [WIDTH-1:0] tree_data;
    logic [CW-2:0]    tree_pos;
    logic             tree_valid;

    logic             in_xfer;
    logic             s2_load;

    logic             s1_valid_q, s1_valid_d;
    s1_payload_t      s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [CW-1:0]    s2_count_q, s2_count_d;
    logic             s2_all_q, s2_all_d;

    assign tree_data = (in_mode == CLZ_MODE_ONES) ? ~in_data : in_data;

    clz_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .data  (tree_data),
        .pos   (tree_pos),
        .valid (tree_valid)
    );

    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        in_xfer  = in_valid && in_ready;

        s1_d = s1_q;
        if (in_xfer) begin
            s1_d.all   = !tree_valid;
            s1_d.count = tree_valid ? {1'b0, tree_pos} : CW'(WIDTH);
`ifdef CLZ_NORM_SHIFTER_EN
            s1_d.data  = in_data;
`endif
        end

        s1_valid_d = in_xfer ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);

        s2_count_d = s2_count_q;
        s2_all_d   = s2_all_q;
        if (s2_load) begin
            s2_count_d = s1_q.count;
            s2_all_d   = s1_q.all;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_count_q <= '0;
            s2_all_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_count_q <= s2_count_d;
            s2_all_q   <= s2_all_d;
        end
    end

`ifdef CLZ_NORM_SHIFTER_EN
    logic [WIDTH-1:0] s2_norm_q, s2_norm_d;
    logic [WIDTH-1:0] norm_sh;

    // An all-equal operand has count WIDTH, whose low bits are zero, so it is forced to 0 explicitly.
    always_comb begin
        norm_sh = s1_q.data;
        for (int unsigned k = 0; k < CW - 1; k++) begin
            if (s1_q.count[k]) begin
                norm_sh = norm_sh << (1 << k);
            end
        end
        if (s1_q.all) begin
            norm_sh = '0;
        end

        s2_norm_d = s2_load ? norm_sh : s2_norm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_norm_q <= '0;
        end else begin
            s2_norm_q <= s2_norm_d;
        end
    end

    assign out_norm = s2_norm_q;
`else
    assign out_norm = '0;
`endif

    assign out_valid = s2_valid_q;
    assign out_count = s2_count_q;
    assign out_all   = s2_all_q;

endmodule

// File: tb/tb_clz_norm_pipe.sv
// Directed bench for clz_norm_pipe at WIDTH=32 and WIDTH=8; honours CLZ_NORM_SHIFTER_EN.
module tb_clz_norm_pipe;

`ifdef CLZ_NORM_SHIFTER_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_all;
    logic [31:0] in_data, out_norm;
    logic [5:0]  out_count;

    logic        v8, r8, m8, ov8, or8, oa8;
    logic [7:0]  d8, on8;
    logic [3:0]  oc8;

    clz_norm_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_all(out_all), .out_norm(out_norm)
    );

    clz_norm_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8), .in_data(d8), .in_mode(m8),
        .out_valid(ov8), .out_ready(or8),
        .out_count(oc8), .out_all(oa8), .out_norm(on8)
    );

    typedef struct {
        int unsigned  cnt;
        bit           all;
        logic [127:0] norm;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        bit          m;
        int unsigned cnt;
        bit          all;
        logic [31:0] norm;
    } vec_t;

    exp_t sb32[$];
    exp_t sb8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   outs32 = 0;
    exp_t mon32_e, mon8_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] gn(input logic [127:0] x);
        return x & {128{SHIFT_EN}};
    endfunction

    function automatic exp_t model(input logic [127:0] d, input bit mode, input int unsigned w);
        exp_t         e;
        logic [127:0] x;
        logic [127:0] mask;
        x     = mode ? ~d : d;
        e.cnt = 0;
        for (int i = int'(w) - 1; i >= 0 && x[i] == 1'b0; i--) e.cnt++;
        e.all  = (e.cnt == w);
        mask   = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        e.norm = e.all ? '0 : gn((d << e.cnt) & mask);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            outs32++;
            if (sb32.size() == 0) begin
                check("w32 unexpected out_valid", 1, 0);
            end else begin
                mon32_e = sb32.pop_front();
                check("w32 count", out_count, mon32_e.cnt);
                check("w32 all", out_all, mon32_e.all);
                check("w32 norm", out_norm, mon32_e.norm);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (sb8.size() == 0) begin
                check("w8 unexpected out_valid", 1, 0);
            end else begin
                mon8_e = sb8.pop_front();
                check("w8 count", oc8, mon8_e.cnt);
                check("w8 all", oa8, mon8_e.all);
                check("w8 norm", on8, mon8_e.norm);
            end
        end
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic step32(input bit v, input logic [31:0] d, input bit m, input bit rdy,
                          input exp_t e, output bit acc);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) sb32.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic [7:0] d, input bit m, output bit acc);
        v8  = 1'b1;
        d8  = d;
        m8  = m;
        or8 = 1'b1;
        @(negedge clk);
        acc = r8;
        if (acc) sb8.push_back(model({120'd0, d}, m, 8));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        v8        = 1'b0;
        or8       = 1'b1;
        for (int i = 0; i < 20 && (sb32.size() != 0 || sb8.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain scoreboard empty", sb32.size() + sb8.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[12];
        exp_t        e;
        bit          acc;
        int          drops;
        int          base;
        logic [31:0] d;
        bit          m;
        logic [5:0]  snap_cnt;
        logic        snap_all;
        logic [31:0] snap_norm;
        logic [31:0] bp_data[5];
        bit          bp_exp_acc[5];
        int          idx;

        tbl[0]  = '{32'h0000_1000, 1'b0, 19, 1'b0, 32'h8000_0000};
        tbl[1]  = '{32'h0000_0000, 1'b0, 32, 1'b1, 32'h0000_0000};
        tbl[2]  = '{32'hFFFF_FFFF, 1'b1, 32, 1'b1, 32'h0000_0000};
        tbl[3]  = '{32'hF0FF_FFFF, 1'b1,  4, 1'b0, 32'h0FFF_FFF0};
        tbl[4]  = '{32'h8000_0000, 1'b0,  0, 1'b0, 32'h8000_0000};
        tbl[5]  = '{32'h7FFF_FFFF, 1'b1,  0, 1'b0, 32'h7FFF_FFFF};
        tbl[6]  = '{32'h0000_0001, 1'b0, 31, 1'b0, 32'h8000_0000};
        tbl[7]  = '{32'hFFFF_FFFE, 1'b1, 31, 1'b0, 32'h0000_0000};
        tbl[8]  = '{32'h0000_FFFF, 1'b0, 16, 1'b0, 32'hFFFF_0000};
        tbl[9]  = '{32'h1234_5678, 1'b0,  3, 1'b0, 32'h91A2_B3C0};
        tbl[10] = '{32'hC000_0000, 1'b1,  2, 1'b0, 32'h0000_0000};
        tbl[11] = '{32'h0080_0000, 1'b1,  0, 1'b0, 32'h0080_0000};

        in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
        v8 = 1'b0; d8 = '0; m8 = 1'b0; or8 = 1'b1;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_count", out_count, 0);
        check("reset out_all", out_all, 0);
        check("reset out_norm", out_norm, 0);
        check("reset w8 out_valid", ov8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);
        @(posedge clk); #1;

        // Single-beat latency
        e = '{cnt: 19, all: 1'b0, norm: gn(128'h8000_0000)};
        step32(1'b1, 32'h0000_1000, 1'b0, 1'b1, e, acc);
        check("latency accept", acc, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency out_valid after 1 cycle", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("latency out_valid after 2 cycles", out_valid, 1);
        @(posedge clk); #1;
        drain();

        // Directed table, streamed back to back
        for (int i = 0; i < 12; i++) begin
            e = '{cnt: tbl[i].cnt, all: tbl[i].all, norm: gn({96'd0, tbl[i].norm})};
            step32(1'b1, tbl[i].d, tbl[i].m, 1'b1, e, acc);
            check($sformatf("table accept %0d", i), acc, 1);
        end
        drain();

        // 64 beats, walking ones then random, full throughput
        drops = 0;
        base  = outs32;
        for (int i = 0; i < 64; i++) begin
            if (i < 32) begin
                d = 32'd1 << i;
                m = i[0];
            end else begin
                d = $urandom() >> $urandom_range(0, 31);
                m = 1'($urandom_range(0, 1));
            end
            step32(1'b1, d, m, 1'b1, model({96'd0, d}, m, 32), acc);
            if (!acc) drops++;
        end
        check("b2b in_ready drops", drops, 0);
        check("b2b results during stream", outs32 - base, 62);
        drain();

        // Backpressure: 5 stalled cycles, then simultaneous in/out with both stages full
        bp_data[0] = 32'h0000_00F0; bp_data[1] = 32'h0003_0000; bp_data[2] = 32'hFFF0_0000;
        bp_data[3] = 32'h0000_0002; bp_data[4] = 32'h0100_0000;
        bp_exp_acc[0] = 1'b1; bp_exp_acc[1] = 1'b1; bp_exp_acc[2] = 1'b0;
        bp_exp_acc[3] = 1'b0; bp_exp_acc[4] = 1'b0;
        idx = 0;
        snap_cnt = '0; snap_all = 1'b0; snap_norm = '0;
        for (int c = 0; c < 5; c++) begin
            step32(1'b1, bp_data[idx], 1'b0, 1'b0, model({96'd0, bp_data[idx]}, 1'b0, 32), acc);
            check($sformatf("bp accept cycle %0d", c), acc, bp_exp_acc[c]);
            if (acc) idx++;
            if (c == 1) begin
                snap_cnt = out_count; snap_all = out_all; snap_norm = out_norm;
            end
        end
        check("bp out_valid held", out_valid, 1);
        check("bp out_count stable", out_count, snap_cnt);
        check("bp out_all stable", out_all, snap_all);
        check("bp out_norm stable", out_norm, snap_norm);
        check("bp stalled beat count", snap_cnt, 24);
        step32(1'b1, bp_data[idx], 1'b0, 1'b1, model({96'd0, bp_data[idx]}, 1'b0, 32), acc);
        check("bp simultaneous in_ready", acc, 1);
        if (acc) idx++;
        while (idx < 5) begin
            step32(1'b1, bp_data[idx], 1'b0, 1'b1, model({96'd0, bp_data[idx]}, 1'b0, 32), acc);
            check($sformatf("bp release accept %0d", idx), acc, 1);
            if (acc) idx++;
        end
        drain();

        // Reset with two beats in flight
        step32(1'b1, 32'h0000_00FF, 1'b0, 1'b0, model(128'hFF, 1'b0, 32), acc);
        step32(1'b1, 32'h0000_0FFF, 1'b0, 1'b0, model(128'hFFF, 1'b0, 32), acc);
        in_valid = 1'b0;
        check("mid-reset pre out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        sb32.delete();
        #1;
        check("mid-reset out_valid", out_valid, 0);
        check("mid-reset out_count", out_count, 0);
        check("mid-reset out_all", out_all, 0);
        check("mid-reset out_norm", out_norm, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("post-reset no stale out_valid %0d", c), out_valid, 0);
        end
        @(posedge clk); #1;

        // WIDTH=8 exhaustive over data and mode
        drops = 0;
        for (int i = 0; i < 512; i++) begin
            step8(8'(i), i[8], acc);
            if (!acc) drops++;
        end
        check("w8 in_ready drops", drops, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clz_norm_pipe.md
Name: clz_norm_pipe

Overview:
- Pipelined, parametrised leading-zero/leading-one counter and normaliser with valid/ready handshakes on input and output.
- Generalises the combinational 2-bit-encode/merge-tree LZD to:
  - any power-of-two width;
  - a per-transaction count mode;
  - a full-range count (including the all-zero case);
  - a registered two-stage pipeline with backpressure.
- Sits ahead of the mantissa/posit normalisation and rounding logic in the arithmetic datapath.

Parameters:
- WIDTH, 32, input data width; power of two, 4..128.
- CW, CLOG2(WIDTH)+1, count width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  WIDTH  operand; bit WIDTH-1 is the most significant bit.
- in_mode  in  1  0 = count leading zeros, 1 = count leading ones.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CW  number of leading bits equal to the counted value.
- out_all  out  1  every bit of in_data equals the counted value.
- out_norm  out  WIDTH  in_data shifted left by out_count, zero-filled (see optional feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - s1_valid, s2_valid, out_valid, out_count, out_all and out_norm all clear to 0.
  - in_ready is 1 from the first cycle after rst_n deasserts.
- Transfers: an input transfer occurs when in_valid&&in_ready on a rising edge; an output transfer occurs when out_valid&&out_ready.
- Stage S1 (register): captures in_data, in_mode, count and all-flag.
  - Count is computed combinationally from the input.
  - Mode 1 inverts the data before the tree.
  - Tree: 2-bit encoders, then log2(WIDTH)-1 merge levels. A merge selects the left half when its valid bit is set, otherwise the right half with the prefix bit set.
  - all = !tree_valid; count = all ? WIDTH : tree_position.
- Stage S2 (register): captures count, all, and data << count (the shift uses count[CW-2:0]; all forces zero). S2 drives the outputs.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 beat per cycle.
- Stage advance rules (bubble-collapsing):
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load.
  - in_ready is combinational from out_ready; no other comb path exists from inputs to outputs.
- Stage valid updates:
  - s1_valid next = in_transfer ? 1 : (s2_load ? 0 : s1_valid).
  - s2_valid next = s2_load ? 1 : (out_ready ? 0 : s2_valid).
- Output stability: while out_valid && !out_ready, all out_* hold stable. Data registers load only on stage enables, never on bubbles.
- Ordering: results leave in input order; nothing is dropped or duplicated.
- Boundary cases:
  - in_data=0 with mode 0, or all-ones with mode 1: count=WIDTH, all=1, norm=0.
  - MSB already equal to the non-counted value: count=0, norm=in_data.
  - Both stages full with out_ready=0: in_ready=0.
  - Simultaneous out transfer and in transfer with both stages full: all three occupants shift by one; in_ready=1 that cycle.
- Reset mid-operation: in-flight beats are discarded and no out_valid appears afterwards for them.
- Mode is per beat and travels with its data; changing in_mode between beats needs no flush.

Optional Feature:
- Macro: CLZ_NORM_SHIFTER_EN.
- Defined: S2 contains the barrel shifter (log2(WIDTH) mux levels) and out_norm behaves as above.
- Undefined:
  - No shifter and no S1 data register is built.
  - out_norm is tied to 0.
  - Count, all, handshake and latency are unchanged (still 2 cycles).

Decomposition:
- Package clz_pkg:
  - CLOG2 constant function;
  - count-mode constants (CLZ_MODE_ZEROS=0, CLZ_MODE_ONES=1);
  - a typedef for the S1→S2 payload struct (data, count, all).
- One combinational sub-module, clz_tree (parameter WIDTH):
  - ports data, pos[CW-2:0], valid;
  - uses 2-bit encode plus recursive merge;
  - verified standalone against a behavioural loop count.

Test Plan (WIDTH=32 unless stated):
- Reset, then single beat: in_data=0x0000_1000, mode 0, out_ready=1 → out_valid exactly 2 cycles later; count=19, all=0, norm=0x8000_0000.
- All-zero and all-ones:
  - 0x0000_0000 mode 0 → count=32, all=1, norm=0.
  - 0xFFFF_FFFF mode 1 → count=32, all=1.
  - 0xF0FF_FFFF mode 1 → count=4, norm=0x0FFF_FFF0.
- Back-to-back: 64 random beats with in_valid=1 and out_ready=1 → one result per cycle, in order, matching the model; in_ready never drops.
- Backpressure: hold out_ready=0 for 5 cycles during a stream → in_ready falls after 2 accepted beats; outputs stay stable; no loss on release. Include a cycle where in and out transfer simultaneously with both stages full.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight → outputs are 0 immediately; no stale out_valid after release.
- Width sweep: WIDTH=4, 8, 64, 128 with exhaustive (4, 8) or random plus walking-one patterns → count and norm match the model. Run with and without CLZ_NORM_SHIFTER_EN; out_norm=0 when undefined.
